// File: rtl/reg_scoreboard_pkg.sv
// Shared CPU register-file constants and helpers used by scheduler, decode and scoreboard.
// Register 0 is hardwired zero and is never tracked as a pending write.
package reg_scoreboard_pkg;

  localparam int NUM_REGS  = 64;
  localparam int REG_IDX_W = 6;
  localparam int CNT_W     = 7;

  localparam logic [REG_IDX_W-1:0] R0_IDX = '0;

  typedef logic [NUM_REGS-1:0]  reg_mask_t;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef struct packed {
    logic waw;
    logic spurious_wb;
  } sb_err_t;

  function automatic reg_mask_t idx2mask(input reg_idx_t idx);
    idx2mask = reg_mask_t'(1) << idx;
  endfunction

endpackage

// File: rtl/reg_scoreboard_popcount64.sv
// Population count of a 64-bit vector as a balanced combinational adder tree.
// No state; output settles in the same cycle as the input.
module popcount64 (
  input  logic [63:0] data_i,
  output logic [6:0]  count_o
);

  logic [1:0] s1 [32];
  logic [2:0] s2 [16];
  logic [3:0] s3 [8];
  logic [4:0] s4 [4];
  logic [5:0] s5 [2];

  always_comb begin
    for (int i = 0; i < 32; i++) s1[i] = {1'b0, data_i[2*i]} + {1'b0, data_i[2*i+1]};
    for (int i = 0; i < 16; i++) s2[i] = {1'b0, s1[2*i]} + {1'b0, s1[2*i+1]};
    for (int i = 0; i < 8; i++)  s3[i] = {1'b0, s2[2*i]} + {1'b0, s2[2*i+1]};
    for (int i = 0; i < 4; i++)  s4[i] = {1'b0, s3[2*i]} + {1'b0, s3[2*i+1]};
    for (int i = 0; i < 2; i++)  s5[i] = {1'b0, s4[2*i]} + {1'b0, s4[2*i+1]};
    count_o = {1'b0, s5[0]} + {1'b0, s5[1]};
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks pending writes per architectural register, with
// same-cycle issue bypass on reg_busy, registered busy count and sticky hazard errors.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int NUM_WB = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        issue_en,
  input  logic [REG_IDX_W-1:0]        issue_rd,
  input  logic [REG_IDX_W-1:0]        issue_rd2,
  input  logic [NUM_WB-1:0]           wb_valid,
  input  logic [REG_IDX_W*NUM_WB-1:0] wb_rn,
  input  logic                        flush,
  output logic [NUM_REGS-1:0]         reg_busy,
  output logic [CNT_W-1:0]            busy_count,
  output logic                        err_waw,
  output logic                        err_spurious_wb
);

  reg_mask_t         busy_q, busy_d;
  reg_mask_t         set_mask, clr_mask;
  logic [CNT_W-1:0]  count_q, count_d;
  sb_err_t           err_q, err_d;
  logic              waw_hit, spur_hit;

  always_comb begin
    set_mask = '0;
    if (issue_en) set_mask = idx2mask(issue_rd) | idx2mask(issue_rd2);
    set_mask[R0_IDX] = 1'b0;
  end

  // Duplicate port clears OR together, so they count as one clear.
  always_comb begin
    clr_mask = '0;
    for (int k = 0; k < NUM_WB; k++) begin
      if (wb_valid[k]) clr_mask = clr_mask | idx2mask(wb_rn[REG_IDX_W*k +: REG_IDX_W]);
    end
  end

  always_comb begin
    spur_hit = 1'b0;
    for (int k = 0; k < NUM_WB; k++) begin
      if (wb_valid[k] && (wb_rn[REG_IDX_W*k +: REG_IDX_W] != R0_IDX) &&
          !busy_q[wb_rn[REG_IDX_W*k +: REG_IDX_W]] &&
          !set_mask[wb_rn[REG_IDX_W*k +: REG_IDX_W]])
        spur_hit = 1'b1;
    end
  end

  // A writeback landing in the issue cycle retires the old producer, so no WAW.
  always_comb begin
    waw_hit = 1'b0;
    if (issue_en) begin
      if ((issue_rd != R0_IDX) && busy_q[issue_rd] && !clr_mask[issue_rd]) waw_hit = 1'b1;
      if ((issue_rd2 != R0_IDX) && busy_q[issue_rd2] && !clr_mask[issue_rd2]) waw_hit = 1'b1;
      if ((issue_rd2 != R0_IDX) && (issue_rd == issue_rd2)) waw_hit = 1'b1;
    end
  end

  always_comb begin
    busy_d = '0;
    if (!flush) busy_d = (busy_q & ~clr_mask) | set_mask;
    busy_d[R0_IDX] = 1'b0;
    err_d.waw         = err_q.waw | waw_hit;
    err_d.spurious_wb = err_q.spurious_wb | spur_hit;
  end

  popcount64 u_popcount (
    .data_i  (busy_d),
    .count_o (count_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= '0;
      count_q <= '0;
      err_q   <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign reg_busy        = rst_n ? (busy_q | set_mask) : '0;
  assign busy_count      = count_q;
  assign err_waw         = err_q.waw;
  assign err_spurious_wb = err_q.spurious_wb;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench: driver pushes model expectations, monitor compares DUT outputs each cycle.
module tb_reg_scoreboard;

  localparam int NWB = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            issue_en = 1'b0;
  logic [5:0]      issue_rd = '0;
  logic [5:0]      issue_rd2 = '0;
  logic [NWB-1:0]  wb_valid = '0;
  logic [6*NWB-1:0] wb_rn = '0;
  logic            flush = 1'b0;
  logic [63:0]     reg_busy;
  logic [6:0]      busy_count;
  logic            err_waw;
  logic            err_spurious_wb;

  reg_scoreboard #(.NUM_WB(NWB)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .issue_en        (issue_en),
    .issue_rd        (issue_rd),
    .issue_rd2       (issue_rd2),
    .wb_valid        (wb_valid),
    .wb_rn           (wb_rn),
    .flush           (flush),
    .reg_busy        (reg_busy),
    .busy_count      (busy_count),
    .err_waw         (err_waw),
    .err_spurious_wb (err_spurious_wb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] busy;
    int          cnt;
    bit          waw;
    bit          sp;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  // Reference model state: one flag per register plus sticky errors and registered count.
  bit m_busy [64];
  int m_cnt = 0;
  bit m_waw = 0;
  bit m_sp  = 0;

  task automatic check(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, want);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, enqueue expected outputs, advance model.
  task automatic step(input bit rst, input bit en, input int rd, input int rd2,
                      input logic [NWB-1:0] wbv, input int rn [NWB], input bit fl);
    exp_t e;
    bit   setm [64];
    bit   clr  [64];
    bit   waw, sp;
    @(negedge clk);
    cyc++;
    rst_n     = rst;
    issue_en  = en;
    issue_rd  = 6'(rd);
    issue_rd2 = 6'(rd2);
    wb_valid  = wbv;
    for (int k = 0; k < NWB; k++) wb_rn[6*k +: 6] = 6'(rn[k]);
    flush     = fl;

    if (!rst) begin
      foreach (m_busy[i]) m_busy[i] = 0;
      m_cnt = 0; m_waw = 0; m_sp = 0;
      e.busy = '0; e.cnt = 0; e.waw = 0; e.sp = 0; e.cyc = cyc;
      q.push_back(e);
      return;
    end

    for (int i = 0; i < 64; i++) begin
      setm[i] = en && (i != 0) && (i == rd || i == rd2);
      clr[i]  = 0;
      for (int k = 0; k < NWB; k++) if (wbv[k] && rn[k] == i) clr[i] = 1;
    end
    for (int i = 0; i < 64; i++) e.busy[i] = m_busy[i] | setm[i];
    e.cnt = m_cnt; e.waw = m_waw; e.sp = m_sp; e.cyc = cyc;
    q.push_back(e);

    waw = en && ((rd != 0 && m_busy[rd] && !clr[rd]) ||
                 (rd2 != 0 && m_busy[rd2] && !clr[rd2]) ||
                 (rd2 != 0 && rd == rd2));
    sp = 0;
    for (int k = 0; k < NWB; k++)
      if (wbv[k] && rn[k] != 0 && !m_busy[rn[k]] && !setm[rn[k]]) sp = 1;
    m_waw |= waw;
    m_sp  |= sp;
    m_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      m_busy[i] = !fl && (i != 0) && (setm[i] || (m_busy[i] && !clr[i]));
      m_cnt += m_busy[i];
    end
  endtask

  task automatic idle();
    int z [NWB] = '{default: 0};
    step(1, 0, 0, 0, '0, z, 0);
  endtask

  // Monitor: the DUT presents a full output set every cycle; compare against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        check("reg_busy", reg_busy, e.busy);
        check("busy_count", busy_count, e.cnt);
        check("err_waw", err_waw, e.waw);
        check("err_spurious_wb", err_spurious_wb, e.sp);
      end
    end
  end

  initial begin
    int z [NWB] = '{default: 0};
    int rn [NWB];
    int bl [$];
    logic [NWB-1:0] wbv;

    // Reset held with issue_en high: bypass must be gated.
    step(0, 1, 5, 6, '0, z, 0);
    step(0, 0, 0, 0, '0, z, 0);

    // Issue r5, then writeback on port 2.
    step(1, 1, 5, 0, '0, z, 0);
    #2 check("d_bypass_r5", reg_busy[5], 1);
    check("d_r0", reg_busy[0], 0);
    idle();
    #2 check("d_cnt_r5", busy_count, 1);
    rn = '{0, 0, 5, 0};
    step(1, 0, 0, 0, 4'b0100, rn, 0);
    #2 check("d_r5_wb_cycle", reg_busy[5], 1);
    idle();
    #2 check("d_r5_cleared", reg_busy[5], 0);
    check("d_cnt_zero", busy_count, 0);

    // r9 busy, reissue while writeback arrives: set wins, no error.
    step(1, 1, 9, 0, '0, z, 0);
    rn = '{9, 0, 0, 0};
    step(1, 1, 9, 0, 4'b0001, rn, 0);
    idle();
    #2 check("d_r9_busy", reg_busy[9], 1);
    check("d_r9_noerr", {err_waw, err_spurious_wb}, 0);
    step(1, 0, 0, 0, 4'b0001, rn, 0);

    // Dual destination, duplicate writeback ports.
    step(1, 1, 12, 13, '0, z, 0);
    rn = '{12, 0, 0, 12};
    step(1, 0, 0, 0, 4'b1001, rn, 0);
    idle();
    #2 check("d_cnt_r13", busy_count, 1);
    check("d_dup_noerr", {err_waw, err_spurious_wb}, 0);
    rn = '{13, 0, 0, 0};
    step(1, 0, 0, 0, 4'b0001, rn, 0);

    // Ten busy registers, then flush with a same-cycle issue.
    for (int i = 0; i < 5; i++) step(1, 1, 30 + 2*i, 31 + 2*i, '0, z, 0);
    idle();
    #2 check("d_cnt_ten", busy_count, 10);
    step(1, 1, 20, 0, '0, z, 1);
    idle();
    #2 check("d_flush_busy", reg_busy, 0);
    check("d_flush_cnt", busy_count, 0);
    rn = '{20, 0, 0, 0};
    step(1, 0, 0, 0, 4'b0001, rn, 0);
    idle();
    #2 check("d_spur_set", err_spurious_wb, 1);
    idle();
    #2 check("d_spur_sticky", err_spurious_wb, 1);

    // WAW on r7, then asynchronous reset mid-cycle.
    step(1, 1, 7, 0, '0, z, 0);
    step(1, 1, 7, 0, '0, z, 0);
    idle();
    #2 check("d_waw_set", err_waw, 1);
    idle();
    #2 check("d_waw_sticky", err_waw, 1);
    step(0, 1, 7, 0, '0, z, 0);
    #1 check("d_async_rst", {reg_busy, busy_count, err_waw, err_spurious_wb}, 0);

    // Randomized traffic; writebacks mostly target busy registers.
    for (int n = 0; n < 1500; n++) begin
      bit en, fl;
      int rd, rd2;
      bl.delete();
      for (int i = 1; i < 64; i++) if (m_busy[i]) bl.push_back(i);
      en  = ($urandom_range(0, 99) < 45);
      rd  = $urandom_range(0, 63);
      rd2 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : 0;
      for (int k = 0; k < NWB; k++) begin
        wbv[k] = ($urandom_range(0, 99) < 20);
        if (bl.size() != 0 && $urandom_range(0, 9) < 8)
          rn[k] = bl[$urandom_range(0, bl.size() - 1)];
        else
          rn[k] = $urandom_range(0, 63);
      end
      fl = ($urandom_range(0, 99) == 0);
      if (n % 400 == 0) step(0, en, rd, rd2, wbv, rn, fl);
      else step(1, en, rd, rd2, wbv, rn, fl);
    end

    @(negedge clk);
    #3;
    check("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have parameter: NUM_WB, 4, number of independent writeback (clear) ports, legal range 1..8.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: issue_en  input  1  instruction issued this cycle (scheduler's OR of unit enables).
REQ-005 SHALL have port: issue_rd  input  6  primary destination register of issued instruction.
REQ-006 SHALL have port: issue_rd2  input  6  secondary destination register (advanced-integer unit); 0 = none.
REQ-007 SHALL have port: wb_valid  input  NUM_WB  per-port writeback strobe.
REQ-008 SHALL have port: wb_rn  input  6*NUM_WB  per-port writeback register number, port k at bits [6k+5:6k].
REQ-009 SHALL have port: flush  input  1  synchronous clear of all busy state (pipeline flush).
REQ-010 SHALL have port: reg_busy  output  64  per-register pending-write flag, consumed by the scheduler.
REQ-011 SHALL have port: busy_count  output  7  number of registers currently busy, registered.
REQ-012 SHALL have port: err_waw  output  1  sticky: issue targeted an already-busy register.
REQ-013 SHALL have port: err_spurious_wb  output  1  sticky: writeback to a register not busy.

Function
REQ-014 SHALL hold a 64-bit registered busy vector busy_q; bit 0 permanently 0 (r0 hardwired zero, never tracked).
REQ-015 SHALL set busy_q[issue_rd] and busy_q[issue_rd2] on the clock edge where issue_en=1, excluding register 0.
REQ-016 SHALL clear busy_q[wb_rn[k]] on the edge where wb_valid[k]=1, for every port k.
REQ-017 SHALL, when set and clear target the same register in the same cycle, leave it busy (set wins; new producer supersedes old writeback).
REQ-018 SHALL treat multiple writeback ports naming the same register in one cycle as a single clear, no error.
REQ-019 SHALL drive reg_busy = busy_q OR current-cycle issue set mask (combinational bypass), so a dependent instruction presented the cycle after issue-decision sees the hazard with zero-cycle gap.
REQ-020 SHALL NOT bypass clears: a register cleared by writeback reads not-busy in reg_busy from the next cycle onward.
REQ-021 SHALL, on flush=1, zero busy_q at the next edge, overriding same-cycle issue and writeback; err flags unaffected.
REQ-022 SHALL update busy_count to the population count of the next busy_q value, i.e. busy_count always equals popcount(busy_q) one cycle-aligned, range 0..63.
REQ-023 SHALL set err_waw when issue_en=1 and issue_rd (or nonzero issue_rd2) is already set in busy_q and not cleared that cycle; also when issue_rd==issue_rd2!=0.
REQ-024 SHALL set err_spurious_wb when wb_valid[k]=1, wb_rn[k]!=0 and busy_q[wb_rn[k]]=0 and not being set that cycle; wb to r0 ignored silently.
REQ-025 SHALL keep error flags set until reset; no other clear path.

Reset
REQ-026 SHALL on rst_n=0 asynchronously force busy_q=0, busy_count=0, err_waw=0, err_spurious_wb=0.
REQ-027 SHALL yield reg_busy=0 while rst_n=0 regardless of issue_en (bypass gated by reset).
REQ-028 SHALL, if reset asserts mid-operation with writes outstanding, discard all pending state; late writebacks after release flag err_spurious_wb (expected, bench must reset execution units too).

Structure
REQ-029 SHALL place NUM_REGS=64, REG_IDX_W=6 and the r0 index constant in the shared CPU package used by scheduler and decode.
REQ-030 SHALL implement population count as sub-module popcount64 (64-bit in, 7-bit out, combinational adder tree).
REQ-031 SHALL build set/clear masks as 64-bit one-hot decodes; no per-register FSM.

Verification
REQ-032 SHALL cover: issue_en=1, rd=5, rd2=0 -> reg_busy[5]=1 same cycle, busy_q[5]=1 next, busy_count=1, reg_busy[0]=0.
REQ-033 SHALL cover: busy r5, wb_valid[2]=1 wb_rn=5 -> reg_busy[5]=1 that cycle, 0 next cycle, busy_count=0.
REQ-034 SHALL cover: busy r9, same cycle issue rd=9 and wb port0 rn=9 -> r9 stays busy, no error flags.
REQ-035 SHALL cover: issue rd=12 rd2=13, then wb ports 0 and 3 both rn=12 same cycle -> r12 clear, r13 busy, busy_count=1, no errors.
REQ-036 SHALL cover: 10 registers busy, flush=1 with issue rd=20 same cycle -> busy_q=0, busy_count=0 next cycle; then wb rn=20 -> err_spurious_wb=1 and stays 1.
REQ-037 SHALL cover: r7 busy, issue rd=7 -> err_waw=1 sticky; async rst_n pulse mid-cycle -> all outputs 0 immediately.
